// File: rtl/ooo_pkg.sv
// ooo_pkg: shared widths and the FU result record for the out-of-order core
package ooo_pkg;
  localparam int DEF_NUM_FU = 4;
  localparam int DEF_PRN_BITS = 6;
  localparam int DEF_INST_ID_BITS = 6;
  typedef struct packed {
    logic [DEF_INST_ID_BITS-1:0] inst_id;
    logic                        wr;
    logic [DEF_PRN_BITS-1:0]     prn;
    logic [63:0]                 value;
  } fu_result_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  // scan farthest-first so the nearest requester at or after ptr wins
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = N'(1) << ((int'(ptr) + k) % N);
        grant_idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: round-robin sharing of the result broadcast bus among FUs
module result_bus_arbiter import ooo_pkg::*; #(
  parameter int NUM_FU = DEF_NUM_FU,
  parameter int PRN_BITS = DEF_PRN_BITS,
  parameter int INST_ID_BITS = DEF_INST_ID_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       fu_valid,
  output logic [NUM_FU-1:0]       fu_ready,
  input  logic [INST_ID_BITS-1:0] fu_inst_id [NUM_FU],
  input  logic [NUM_FU-1:0]       fu_wr,
  input  logic [PRN_BITS-1:0]     fu_prn [NUM_FU],
  input  logic [63:0]             fu_value [NUM_FU],
  output logic                    result_valid,
  output logic                    result_wr,
  output logic [INST_ID_BITS-1:0] result_inst_id,
  output logic [PRN_BITS-1:0]     result_prn,
  output logic [63:0]             result_value
);
  localparam int IW = $clog2(NUM_FU);
  logic [NUM_FU-1:0] slot_v;
  logic [NUM_FU-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     rr_ptr;
  fu_result_t        slot [NUM_FU];
  rr_arbiter #(.N(NUM_FU), .IW(IW)) u_arb (
    .req(slot_v),
    .ptr(rr_ptr),
    .grant(grant),
    .grant_idx(grant_idx)
  );
  assign fu_ready = ~slot_v | grant;
  // slot payload loads on handshake; validity alone governs whether it matters
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++)
      if (fu_valid[i] && fu_ready[i])
        slot[i] <= '{inst_id: fu_inst_id[i], wr: fu_wr[i], prn: fu_prn[i], value: fu_value[i]};
  end
  // slot occupancy, round-robin pointer and registered broadcast
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v <= '0;
      rr_ptr <= '0;
      result_valid <= 1'b0;
      result_wr <= 1'b0;
      result_inst_id <= '0;
      result_prn <= '0;
      result_value <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++)
        if (fu_valid[i] && fu_ready[i]) slot_v[i] <= 1'b1;
        else if (grant[i]) slot_v[i] <= 1'b0;
      result_valid <= |grant;
      if (|grant) begin
        result_wr <= slot[grant_idx].wr;
        result_inst_id <= slot[grant_idx].inst_id;
        result_prn <= slot[grant_idx].prn;
        result_value <= slot[grant_idx].value;
        rr_ptr <= (grant_idx == IW'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter: directed table and sequence checks of the result bus arbiter
module tb_result_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fu_valid, fu_ready, fu_wr;
  logic [5:0]  fu_inst_id [4];
  logic [5:0]  fu_prn [4];
  logic [63:0] fu_value [4];
  logic        result_valid, result_wr;
  logic [5:0]  result_inst_id, result_prn;
  logic [63:0] result_value;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [3:0] v;
    logic [3:0] tag;
    logic [3:0] ready;
    logic       rv;
    logic [5:0] id;
  } vec_t;
  vec_t tbl [12];
  result_bus_arbiter dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_inst_id(fu_inst_id), .fu_wr(fu_wr), .fu_prn(fu_prn), .fu_value(fu_value),
    .result_valid(result_valid), .result_wr(result_wr), .result_inst_id(result_inst_id),
    .result_prn(result_prn), .result_value(result_value)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] val_of(input logic [5:0] id);
    return 64'hC0DE_0000_0000_0000 | 64'(id);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic drive(input int i, input logic [5:0] id);
    fu_inst_id[i] = id;
    fu_wr[i] = id[0];
    fu_prn[i] = id ^ 6'h3F;
    fu_value[i] = val_of(id);
  endtask
  task automatic chk_bc(input string nm, input logic v, input logic [5:0] id);
    chk({nm, ".valid"}, 64'(result_valid), 64'(v));
    if (v) begin
      chk({nm, ".id"}, 64'(result_inst_id), 64'(id));
      chk({nm, ".wr"}, 64'(result_wr), 64'(id[0]));
      chk({nm, ".prn"}, 64'(result_prn), 64'(id ^ 6'h3F));
      chk({nm, ".value"}, result_value, val_of(id));
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fu_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b0;
    fu_valid = '0;
    for (int i = 0; i < 4; i++) drive(i, 6'h00);
    tbl[0]  = '{4'h0, 4'h0, 4'hF, 1'b0, 6'h00};
    tbl[1]  = '{4'hF, 4'h1, 4'hF, 1'b0, 6'h00};
    tbl[2]  = '{4'h0, 4'h1, 4'h1, 1'b1, 6'h01};
    tbl[3]  = '{4'h0, 4'h1, 4'h3, 1'b1, 6'h11};
    tbl[4]  = '{4'h1, 4'h2, 4'h7, 1'b1, 6'h21};
    tbl[5]  = '{4'h0, 4'h2, 4'hE, 1'b1, 6'h31};
    tbl[6]  = '{4'h0, 4'h2, 4'hF, 1'b1, 6'h02};
    tbl[7]  = '{4'h0, 4'h2, 4'hF, 1'b0, 6'h00};
    tbl[8]  = '{4'h9, 4'h3, 4'hF, 1'b0, 6'h00};
    tbl[9]  = '{4'h0, 4'h3, 4'hE, 1'b1, 6'h33};
    tbl[10] = '{4'h0, 4'h3, 4'hF, 1'b1, 6'h03};
    tbl[11] = '{4'h0, 4'h3, 4'hF, 1'b0, 6'h00};
    do_reset();
    #1;
    chk("reset.ready", 64'(fu_ready), 64'hF);
    chk("reset.valid", 64'(result_valid), 64'h0);
    chk("reset.wr", 64'(result_wr), 64'h0);
    chk("reset.id", 64'(result_inst_id), 64'h0);
    chk("reset.prn", 64'(result_prn), 64'h0);
    chk("reset.value", result_value, 64'h0);
    // single uncontested result from FU1, then pointer position check
    @(negedge clk);
    fu_valid = 4'b0010;
    fu_inst_id[1] = 6'd5;
    fu_wr[1] = 1'b1;
    fu_prn[1] = 6'd12;
    fu_value[1] = 64'hDEAD;
    @(posedge clk);
    #1 chk("solo.n1", 64'(result_valid), 64'h0);
    @(negedge clk);
    fu_valid = '0;
    @(posedge clk);
    #1;
    chk("solo.valid", 64'(result_valid), 64'h1);
    chk("solo.id", 64'(result_inst_id), 64'd5);
    chk("solo.wr", 64'(result_wr), 64'h1);
    chk("solo.prn", 64'(result_prn), 64'd12);
    chk("solo.value", result_value, 64'hDEAD);
    @(posedge clk);
    #1 chk("solo.n3", 64'(result_valid), 64'h0);
    @(negedge clk);
    fu_valid = 4'b0111;
    for (int i = 0; i < 3; i++) drive(i, 6'({2'(i), 4'hA}));
    @(negedge clk);
    fu_valid = '0;
    @(posedge clk);
    #1 chk_bc("ptr2.a", 1'b1, 6'h2A);
    @(posedge clk);
    #1 chk_bc("ptr2.b", 1'b1, 6'h0A);
    @(posedge clk);
    #1 chk_bc("ptr2.c", 1'b1, 6'h1A);
    // table: all-four burst, wrap, mid-pointer priority
    do_reset();
    for (int r = 0; r < 12; r++) begin
      if (r > 0) @(negedge clk);
      fu_valid = tbl[r].v;
      for (int i = 0; i < 4; i++) drive(i, 6'({2'(i), tbl[r].tag}));
      #1 chk($sformatf("tbl%0d.ready", r), 64'(fu_ready), 64'(tbl[r].ready));
      @(posedge clk);
      #1 chk_bc($sformatf("tbl%0d", r), tbl[r].rv, tbl[r].id);
    end
    // FU2 streaming back-to-back
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      fu_valid = 4'b0100;
      drive(2, 6'(6'h20 + k));
      #1 chk($sformatf("stream%0d.ready2", k), 64'(fu_ready[2]), 64'h1);
      @(posedge clk);
      #1 if (k == 0) chk("stream0.valid", 64'(result_valid), 64'h0);
         else chk_bc($sformatf("stream%0d", k), 1'b1, 6'(6'h20 + k - 1));
    end
    @(negedge clk);
    fu_valid = '0;
    @(posedge clk);
    #1 chk_bc("stream.last", 1'b1, 6'h27);
    @(posedge clk);
    #1 chk("stream.idle", 64'(result_valid), 64'h0);
    // FU0 and FU3 both continuously valid
    do_reset();
    begin
      int n0, n3;
      logic [3:0] er;
      n0 = 0;
      n3 = 0;
      for (int k = 0; k < 7; k++) begin
        if (k > 0) @(negedge clk);
        fu_valid = 4'b1001;
        drive(0, 6'(n0));
        drive(3, 6'(6'h30 + n3));
        er = (k == 0) ? 4'b1001 : (k % 2 == 1) ? 4'b0001 : 4'b1000;
        #1 chk($sformatf("alt%0d.ready", k), 64'(fu_ready & 4'b1001), 64'(er));
        @(posedge clk);
        #1 if (k == 0) chk("alt0.valid", 64'(result_valid), 64'h0);
           else chk_bc($sformatf("alt%0d", k), 1'b1, 6'(((k % 2 == 1) ? 6'h00 : 6'h30) + (k - 1) / 2));
        if (er[0]) n0++;
        if (er[3]) n3++;
      end
    end
    // reset while three slots are occupied
    do_reset();
    fu_valid = 4'b0111;
    for (int i = 0; i < 3; i++) drive(i, 6'({2'(i), 4'hB}));
    @(negedge clk);
    fu_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid.valid", 64'(result_valid), 64'h0);
    chk("rstmid.ready", 64'(fu_ready), 64'hF);
    chk("rstmid.id", 64'(result_inst_id), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk($sformatf("rstmid.idle%0d", k), 64'(result_valid), 64'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_bus_arbiter.md
# result_bus_arbiter

Shares the single result broadcast bus between NUM_FU functional units. Each FU hands completed results into a one-entry holding slot. A round-robin arbiter picks one slot per cycle and drives the registered broadcast (result_valid/result_prn/result_value) seen by every issue queue, the PRF write port and the ROB completion logic. It sits between the FU outputs and the wakeup/writeback fabric.

## Interface
Parameters:
- NUM_FU, 4, number of requesting functional units (≥2)
- PRN_BITS, 6, physical register number width
- INST_ID_BITS, 6, ROB instruction id width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fu_valid[NUM_FU]  in  1  FU i presents a completed result
- fu_ready[NUM_FU]  out  1  FU i result accepted this cycle when fu_valid[i] is also high
- fu_inst_id[NUM_FU]  in  INST_ID_BITS  completing instruction id
- fu_wr[NUM_FU]  in  1  result writes a destination register
- fu_prn[NUM_FU]  in  PRN_BITS  destination PRN (ignored when fu_wr=0)
- fu_value[NUM_FU]  in  64  result value
- result_valid  out  1  completion broadcast valid
- result_wr  out  1  broadcast carries a register write (PRF write, IQ wakeup)
- result_inst_id  out  INST_ID_BITS  completing id
- result_prn  out  PRN_BITS  written PRN
- result_value  out  64  written value

## Operation
- Per-FU slot state: slot_v, inst_id, wr, prn, value.
- Handshake: FU i transfers on a cycle where fu_valid[i]=1 and fu_ready[i]=1. The slot loads on that edge.
- fu_ready[i] = !slot_v[i] || grant[i]. This is combinational from the current slot state only, never from fu_valid.
- Arbitration: the request vector is slot_v. The grant is one-hot and goes to the first valid slot at or after rr_ptr, wrapping modulo NUM_FU. No valid slot means no grant.
- On a grant g:
  - The output registers load slot g contents, with result_valid=1.
  - slot_v[g] clears, unless the same cycle's handshake on FU g refills it.
  - rr_ptr advances to (g+1) mod NUM_FU.
- With no grant: result_valid=0 next cycle and rr_ptr holds. The other output fields also hold.
- result_wr=0 results still complete in the ROB. In that case result_prn and result_value are don't-care but driven from the slot.
- Fairness: a valid slot is granted within NUM_FU cycles.
- Only the grant empties a slot, so results are never dropped.
- Ordering is guaranteed per FU; there is no ordering across FUs.

## Timing
- Reset values: all slot_v=0, rr_ptr=0, and result_valid, result_wr, result_inst_id, result_prn, result_value all 0. After reset, fu_ready is all 1.
- Latency: a handshake in cycle N, uncontested, gives the broadcast at cycle N+2 (slot load at the N edge, grant in N+1, output register at the N+1 edge).
- Throughput: one broadcast per cycle aggregate. A single uncontested FU sustains one result per cycle because of the grant-refill path.
- Contended FU: fu_ready[i]=0 until its slot is granted, and the FU must hold its outputs stable.
- Simultaneous grant and refill of the same slot: the new data is written, slot_v stays 1, and the output takes the old data.
- rst asserted mid-operation: slot contents are discarded on the next edge and outputs return to the reset values. The upstream flush is responsible for squashed instructions.
- Wrap-around: when rr_ptr=NUM_FU-1 and slot NUM_FU-1 is granted, rr_ptr becomes 0.

## Structure
- Shared package (ooo_pkg):
  - typedef fu_result_t {inst_id, wr, prn, value}, parameterised by PRN_BITS and INST_ID_BITS via package constants.
  - Constant NUM_FU default.
- Sub-module rr_arbiter (N, req[N], ptr → grant one-hot, grant_idx).
  - Purely combinational.
  - Reused by the dispatch steering logic.
- The slot array and output registers live in result_bus_arbiter.

## Test plan
- Reset, then FU1 alone sends {id=5, wr=1, prn=12, value=0xDEAD} at cycle 3 → result_valid=1 with those fields at cycle 5 only; rr_ptr=2.
- All 4 FUs valid in the same cycle with rr_ptr=0 → broadcasts in order FU0, FU1, FU2, FU3 on 4 consecutive cycles. Each fu_ready is low until its own grant cycle.
- FU2 streams 8 back-to-back results, others idle → 8 consecutive result_valid cycles in FU2 order, fu_ready[2] always 1.
- FU0 and FU3 both continuously valid → grants alternate 0, 3, 0, 3; neither waits more than 1 cycle between grants.
- FU1 sends wr=0 id=9 → result_valid=1, result_wr=0, result_inst_id=9.
- Assert rst while 3 slots are full → next cycle result_valid=0 and all fu_ready=1. No stale result is broadcast afterward.
